// File: rtl/modexp_pkg.sv
// Shared constants and FSM encoding for the modular exponentiation master.
// Imported by the master and by anything that sits next to it.
package modexp_pkg;

    localparam int OPW         = 256;
    localparam int WORDW       = 32;
    localparam int IDXW        = 8;
    localparam int TIMEOUT_DEF = 31;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        CAPTURE,
        FINISH,
        FAIL
    } state_t;

endpackage

// File: rtl/modexp_master.sv
// Left-to-right square-and-multiply sequencer driving an external
// Montgomery slave, one slave operation per exponent bit.
module modexp_master
    import modexp_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [OPW-1:0]   exponent,
    input  logic [8:0]       exp_bits,
    input  logic [OPW-1:0]   base_mont,
    input  logic [OPW-1:0]   one_mont,
    input  logic [OPW-1:0]   modulus,
    input  logic [WORDW-1:0] mp,
    output logic             slv_en,
    output logic             slv_pow_bit,
    output logic [OPW-1:0]   slv_multiplicand,
    output logic [OPW-1:0]   slv_indata,
    output logic [OPW-1:0]   slv_modulos,
    output logic [WORDW-1:0] slv_mp,
    input  logic             slv_endflag,
    input  logic [OPW-1:0]   slv_answer,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [OPW-1:0]   result
);

    localparam int CW = $clog2(TIMEOUT + 1) + 1;

    state_t          state;
    logic [OPW-1:0]  exp_r;
    logic [OPW-1:0]  acc;
    logic [IDXW-1:0] idx;
    logic [IDXW-1:0] top_idx;
    logic [CW-1:0]   cnt;
    logic [8:0]      nbits;

    // Anything wider than the operand is clamped to the full operand
    assign nbits   = (exp_bits > 9'd256) ? 9'd256 : exp_bits;
    assign top_idx = IDXW'(nbits - 9'd1);

    // The slave always sees the live accumulator; it only moves in CAPTURE
    assign slv_multiplicand = acc;

    // Sequencer: one LOAD/RUN/CAPTURE round per exponent bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            slv_en      <= 1'b0;
            slv_pow_bit <= 1'b0;
            slv_indata  <= '0;
            slv_modulos <= '0;
            slv_mp      <= '0;
            exp_r       <= '0;
            acc         <= '0;
            idx         <= '0;
            cnt         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            result      <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        exp_r       <= exponent;
                        slv_indata  <= base_mont;
                        slv_modulos <= modulus;
                        slv_mp      <= mp;
                        acc         <= one_mont;
                        idx         <= top_idx;
                        slv_pow_bit <= exponent[top_idx];
                        cnt         <= '0;
                        error       <= 1'b0;
                        busy        <= 1'b1;
                        state       <= (nbits == 9'd0) ? FINISH : LOAD;
                    end
                end
                LOAD: begin
                    slv_en <= 1'b1;
                    cnt    <= '0;
                    state  <= RUN;
                end
                RUN: begin
                    if (slv_endflag) begin
                        slv_en <= 1'b0;
                        state  <= CAPTURE;
                    end else if (cnt == CW'(TIMEOUT)) begin
                        slv_en <= 1'b0;
                        state  <= FAIL;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                CAPTURE: begin
                    acc <= slv_answer;
                    if (idx == '0) begin
                        state <= FINISH;
                    end else begin
                        idx         <= idx - 1'b1;
                        slv_pow_bit <= exp_r[idx - 1'b1];
                        state       <= LOAD;
                    end
                end
                FINISH: begin
                    result <= acc;
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                FAIL: begin
                    error <= 1'b1;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_modexp_master.sv
// Bench for modexp_master with a behavioural word-serial Montgomery slave
// and a queue of expected completions checked on every done pulse.
module tb_modexp_master;

    localparam int TO = 31;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [255:0] exponent;
    logic [8:0]   exp_bits;
    logic [255:0] base_mont;
    logic [255:0] one_mont;
    logic [255:0] modulus;
    logic [31:0]  mp;
    logic         slv_en;
    logic         slv_pow_bit;
    logic [255:0] slv_multiplicand;
    logic [255:0] slv_indata;
    logic [255:0] slv_modulos;
    logic [31:0]  slv_mp;
    logic         slv_endflag;
    logic [255:0] slv_answer;
    logic         busy;
    logic         done;
    logic         error;
    logic [255:0] result;

    modexp_master #(.TIMEOUT(TO)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .exponent         (exponent),
        .exp_bits         (exp_bits),
        .base_mont        (base_mont),
        .one_mont         (one_mont),
        .modulus          (modulus),
        .mp               (mp),
        .slv_en           (slv_en),
        .slv_pow_bit      (slv_pow_bit),
        .slv_multiplicand (slv_multiplicand),
        .slv_indata       (slv_indata),
        .slv_modulos      (slv_modulos),
        .slv_mp           (slv_mp),
        .slv_endflag      (slv_endflag),
        .slv_answer       (slv_answer),
        .busy             (busy),
        .done             (done),
        .error            (error),
        .result           (result)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [255:0] got,
                         input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ---------------- reference arithmetic ----------------
    function automatic logic [255:0] mulmod(input logic [255:0] a,
                                            input logic [255:0] b,
                                            input logic [255:0] m);
        logic [511:0] t;
        t = 512'(a) * 512'(b);
        return 256'(t % 512'(m));
    endfunction

    function automatic logic [255:0] powmod(input logic [255:0] b,
                                            input logic [255:0] e,
                                            input int n,
                                            input logic [255:0] m);
        logic [255:0] r;
        r = 256'd1;
        for (int i = n - 1; i >= 0; i--) begin
            r = mulmod(r, r, m);
            if (e[i]) r = mulmod(r, b, m);
        end
        return r;
    endfunction

    function automatic logic [255:0] to_mont(input logic [255:0] x,
                                             input logic [255:0] m);
        logic [511:0] t;
        t = {x, 256'b0};
        return 256'(t % 512'(m));
    endfunction

    function automatic logic [31:0] calc_mp(input logic [31:0] m0);
        logic [31:0] x;
        x = m0;
        for (int i = 0; i < 5; i++) x = x * (32'd2 - m0 * x);
        return 32'd0 - x;
    endfunction

    // Word-serial Montgomery product a*b*2^-256 mod m (slave arithmetic)
    function automatic logic [255:0] mont(input logic [255:0] a,
                                          input logic [255:0] b,
                                          input logic [255:0] m,
                                          input logic [31:0] p);
        logic [575:0] t;
        logic [31:0]  u;
        t = 576'(a) * 576'(b);
        for (int i = 0; i < 8; i++) begin
            u = t[31:0] * p;
            t = (t + 576'(u) * 576'(m)) >> 32;
        end
        if (t >= 576'(m)) t = t - 576'(m);
        return t[255:0];
    endfunction

    // ---------------- behavioural slave ----------------
    logic         sl_flag;
    logic         stray;
    logic [255:0] sl_x;
    logic [255:0] sl_ans;
    int           sl_cnt;
    bit           sl_dead;
    int           sdly;

    assign slv_endflag = sl_flag | stray;
    assign slv_answer  = sl_ans;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sl_cnt  <= 0;
            sl_flag <= 1'b0;
            sl_ans  <= '0;
            sl_x    <= '0;
        end else if (!slv_en) begin
            sl_cnt  <= 0;
            sl_flag <= 1'b0;
            sl_x    <= slv_multiplicand;
        end else begin
            sl_cnt  <= sl_cnt + 1;
            sl_flag <= 1'b0;
            if (!sl_dead && sl_cnt == sdly - 1) begin
                sl_flag <= 1'b1;
                if (slv_pow_bit)
                    sl_ans <= mont(mont(sl_x, sl_x, slv_modulos, slv_mp),
                                   slv_indata, slv_modulos, slv_mp);
                else
                    sl_ans <= mont(sl_x, sl_x, slv_modulos, slv_mp);
            end
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [255:0] res;
        logic         err;
        int           lat;
        int           ops;
        logic [255:0] seq;
        int           t0;
    } exp_t;

    exp_t         sb[$];
    logic [255:0] M;
    logic [31:0]  MP;
    logic [255:0] model_res;
    int           rises;
    int           rise_cyc;
    logic [255:0] seq;
    logic         prev_en;

    initial begin
        exp_t e;
        rises   = 0;
        seq     = '0;
        prev_en = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_en = 1'b0;
                rises   = 0;
                seq     = '0;
            end else begin
                if (slv_en && !prev_en) begin
                    rises++;
                    seq      = {seq[254:0], slv_pow_bit};
                    rise_cyc = cyc;
                end
                prev_en = slv_en;
                if (done) begin
                    if (sb.size() == 0) begin
                        check("spurious_done", done, 0);
                    end else begin
                        e = sb.pop_front();
                        check("result", result, e.res);
                        check("error", error, e.err);
                        check("latency", cyc - e.t0, e.lat);
                        check("ops", rises, e.ops);
                        check("powseq", seq, e.seq);
                        if (e.err) check("to_gap", cyc - rise_cyc, TO + 2);
                    end
                    rises = 0;
                    seq   = '0;
                end
            end
        end
    end

    task automatic issue(input logic [255:0] e, input logic [8:0] nb,
                         input logic [255:0] bp, input bit dead,
                         input int d);
        exp_t         x;
        int           n;
        logic [255:0] mask;
        n    = (nb > 9'd256) ? 256 : int'(nb);
        mask = (n == 256) ? '1 : ((256'd1 << n) - 256'd1);
        @(negedge clk);
        exponent  = e;
        exp_bits  = nb;
        base_mont = to_mont(bp, M);
        one_mont  = to_mont(256'd1, M);
        modulus   = M;
        mp        = MP;
        sl_dead   = dead;
        sdly      = d;
        start     = 1'b1;
        x.t0      = cyc;
        if (dead) begin
            x.res = model_res;
            x.err = 1'b1;
            x.lat = TO + 4;
            x.ops = 1;
            x.seq = {255'b0, e[n-1]};
        end else begin
            x.res     = to_mont(powmod(bp, e, n, M), M);
            model_res = x.res;
            x.err     = 1'b0;
            x.lat     = 2 + n * (3 + d);
            x.ops     = n;
            x.seq     = e & mask;
        end
        sb.push_back(x);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("drain", sb.size(), 0);
        sb.delete();
    endtask

    function automatic logic [255:0] rnd256();
        return {$urandom(), $urandom(), $urandom(), $urandom(),
                $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    initial begin
        int n;
        M         = (256'd1 << 255) - 256'd19;
        MP        = calc_mp(M[31:0]);
        model_res = '0;
        rst_n     = 1'b0;
        start     = 1'b0;
        stray     = 1'b0;
        exponent  = '0;
        exp_bits  = '0;
        base_mont = '0;
        one_mont  = '0;
        modulus   = '0;
        mp        = '0;
        sl_dead   = 1'b0;
        sdly      = 1;

        #12;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_en", slv_en, 0);
        check("rst_result", result, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // zero-length exponent
        issue(256'h1234, 9'd0, 256'd7, 1'b0, 2);
        drain(100);

        // E = 0b101
        issue(256'd5, 9'd3, 256'd123456789, 1'b0, 2);
        drain(200);

        // random short exponent
        issue(rnd256(), 9'd17, rnd256(), 1'b0, 1);
        drain(500);

        // slave takes the longest time still accepted
        issue(256'd3, 9'd2, rnd256(), 1'b0, TO);
        drain(500);

        // full-width all-ones exponent
        issue('1, 9'd256, rnd256(), 1'b0, 1);
        drain(3000);

        // oversize exp_bits is clamped
        issue(rnd256(), 9'd300, rnd256(), 1'b0, 1);
        drain(3000);

        // start during busy is ignored
        issue(rnd256(), 9'd8, rnd256(), 1'b0, 3);
        repeat (3) @(negedge clk);
        check("busy_hold", busy, 1);
        exponent  = rnd256();
        base_mont = rnd256();
        exp_bits  = 9'd5;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain(500);

        // endflag while idle does nothing
        @(negedge clk);
        stray = 1'b1;
        @(negedge clk);
        stray = 1'b0;
        repeat (4) @(negedge clk);
        check("stray_busy", busy, 0);

        // dead slave -> timeout
        issue(256'd5, 9'd3, 256'd99, 1'b1, 1);
        drain(200);
        check("err_sticky", error, 1);

        // next start clears error
        issue(256'd6, 9'd3, 256'd42, 1'b0, 1);
        check("err_clear", error, 0);
        drain(200);

        // reset in the middle of a long operation
        issue('1, 9'd256, rnd256(), 1'b0, 1);
        n = 0;
        while (!(rises == 100 && slv_en) && n < 3000) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("reach_bit", rises, 100);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_busy", busy, 0);
        check("mid_done", done, 0);
        check("mid_en", slv_en, 0);
        check("mid_result", result, 0);
        check("mid_pow", slv_pow_bit, 0);
        check("mid_mult", slv_multiplicand, 0);
        check("mid_data", slv_indata | slv_modulos, 0);
        check("mid_mp", slv_mp, 0);
        sb.delete();
        model_res = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        issue(rnd256(), 9'd12, rnd256(), 1'b0, 2);
        drain(500);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
